// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, register
// select map and the priority helper used to pick the serviced request.
package interrupt_controller_pkg;

    localparam int NUM_IRQ = 8;

    localparam logic [3:0] REG_PENDING = 4'h0;
    localparam logic [3:0] REG_MASK    = 4'h1;
    localparam logic [3:0] REG_VBASE   = 4'h2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Bit 0 is the highest priority, so the lowest set index wins.
    function automatic logic [2:0] lowest_index(input logic [NUM_IRQ-1:0] vec);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Two-flop synchroniser plus rising-edge detector for a vector of
// asynchronous interrupt requests.
module irq_edge_detect #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] irq,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [2:0]       live;

    // live[k] marks that stage k holds a sample taken after reset, so a line
    // held high through reset never looks like a fresh edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            live  <= '0;
        end else begin
            // NOTE: non-blocking so each stage captures its predecessor's pre-edge value.
            sync1 <= irq;
            sync2 <= sync1;
            prev  <= sync2;
            live  <= {live[1:0], 1'b1};
        end
    end

    assign rise = live[2] ? (sync2 & ~prev) : '0;

endmodule

// File: rtl/interrupt_controller.sv
// Single-level vectored interrupt controller: pending/mask/vector-base
// registers on a strobed register bus, with a request/service handshake.
module interrupt_controller
    import interrupt_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  irq,
    input  logic        io_read,
    input  logic        io_write,
    input  logic        io_push,
    input  logic        io_store_retaddr,
    input  logic        io_push_retaddr,
    input  logic        io_push_ints,
    input  logic        io_push_int_addr,
    output logic        io_interrupt,
    input  logic [15:0] d_addr,
    inout  wire  [15:0] d_bus
);

    state_t      state;
    logic [7:0]  pending;
    logic [7:0]  mask;
    logic [15:0] vbase;
    logic [15:0] retaddr;
    logic [2:0]  id;
    logic [3:0]  sel;

    logic [7:0]  rise;
    logic [7:0]  active;
    logic [7:0]  pending_nxt;
    logic        accept;
    logic        drive_en;
    logic [15:0] int_addr;
    logic [15:0] reg_rdata;
    logic [15:0] bus_out;
    logic        addr_hi_unused;

    assign addr_hi_unused = ^d_addr[15:4];

    irq_edge_detect #(
        .WIDTH (NUM_IRQ)
    ) u_edge (
        .clk  (clk),
        .rst  (rst),
        .irq  (irq),
        .rise (rise)
    );

    assign active   = pending & mask;
    assign accept   = (state == ST_REQUEST) && io_store_retaddr && (active != '0);
    assign int_addr = vbase + {12'h000, id, 1'b0};

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        reg_rdata = '0;
        case (sel)
            REG_PENDING: reg_rdata = {8'h00, pending};
            REG_MASK:    reg_rdata = {8'h00, mask};
            REG_VBASE:   reg_rdata = vbase;
            default:     reg_rdata = '0;
        endcase
    end

    // Exactly one source reaches the bus, highest-precedence strobe first.
    always_comb begin
        bus_out = reg_rdata;
        if (io_push_int_addr) begin
            bus_out = (state == ST_SERVICE) ? int_addr : '0;
        end else if (io_push_retaddr) begin
            bus_out = retaddr;
        end else if (io_push_ints) begin
            bus_out = {mask, pending};
        end
    end

    assign drive_en = !rst && (io_push || io_push_ints || io_push_retaddr || io_push_int_addr);
    assign d_bus    = drive_en ? bus_out : 'z;

    // Clears are applied before the new edges are OR-ed in, so a set wins.
    always_comb begin
        pending_nxt = pending;
        if (io_write && (sel == REG_PENDING)) begin
            pending_nxt = pending_nxt & ~d_bus[7:0];
        end
        if (accept) begin
            pending_nxt = pending_nxt & ~(8'b1 << lowest_index(active));
        end
        pending_nxt = pending_nxt | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            mask    <= '0;
            vbase   <= '0;
            sel     <= '0;
        end else begin
            pending <= pending_nxt;
            if (io_read) begin
                sel <= d_addr[3:0];
            end
            if (io_write) begin
                case (sel)
                    REG_MASK:  mask  <= d_bus[7:0];
                    REG_VBASE: vbase <= d_bus;
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            io_interrupt <= 1'b0;
            retaddr      <= '0;
            id           <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (active != '0) begin
                        state        <= ST_REQUEST;
                        io_interrupt <= 1'b1;
                    end
                end
                ST_REQUEST: begin
                    if (active == '0) begin
                        state        <= ST_IDLE;
                        io_interrupt <= 1'b0;
                    end else if (io_store_retaddr) begin
                        state        <= ST_SERVICE;
                        io_interrupt <= 1'b0;
                        retaddr      <= d_bus;
                        id           <= lowest_index(active);
                    end
                end
                ST_SERVICE: begin
                    // New edges only accumulate here; no nesting.
                    if (io_push_retaddr) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    io_interrupt <= 1'b0;
                end
            endcase
        end
    end

endmodule
